// File: rtl/lr35902_irq.sv
// lr35902_irq: IF/IE interrupt controller with priority vector and ack clear.
// Optional LR35902_IRQ_EDGE_EN selects rising-edge source detection (default: level-sensitive).
module lr35902_irq (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] dout,
   input  logic [7:0] din,
   input  logic       adr,
   input  logic       read,
   input  logic       write,
   input  logic [4:0] irq_in,
   input  logic       int_ack,
   output logic       int_req,
   output logic [7:0] int_vec
);
   logic [4:0] if_q, if_d, pend, ack_m, set;
   logic [7:0] ie_q, ie_d, dout_q, dout_d, wdin_q, wdin_d;
   logic       pread_q, pwrite_q, pack_q, wr_q, wr_d, wadr_q, wadr_d;
`ifdef LR35902_IRQ_EDGE_EN
   logic [4:0] src_q;
   assign set = irq_in & ~src_q;
`else
   assign set = irq_in;
`endif
   assign dout = dout_q;
   always_comb begin
      pend    = if_q & ie_q[4:0];
      // isolate the lowest pending bit; nothing is cleared when no request remains
      ack_m   = (int_ack && !pack_q) ? (pend & (~pend + 5'd1)) : 5'd0;
      int_req = |pend;
      int_vec = pend[0] ? 8'h40 : pend[1] ? 8'h48 : pend[2] ? 8'h50 :
                pend[3] ? 8'h58 : pend[4] ? 8'h60 : 8'h00;
      wr_d    = pwrite_q && !write;
      wadr_d  = wr_d ? adr : wadr_q;
      wdin_d  = wr_d ? din : wdin_q;
      ie_d    = (wr_q && wadr_q) ? wdin_q : ie_q;
      if_d    = (((wr_q && !wadr_q) ? wdin_q[4:0] : if_q) & ~ack_m) | set;
      dout_d  = (read && !pread_q) ? (adr ? ie_q : {3'b111, if_q}) : dout_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         if_q     <= 5'd0;
         ie_q     <= 8'd0;
         dout_q   <= 8'd0;
         wdin_q   <= 8'd0;
         wadr_q   <= 1'b0;
         wr_q     <= 1'b0;
         pread_q  <= 1'b0;
         pwrite_q <= 1'b0;
         pack_q   <= 1'b0;
`ifdef LR35902_IRQ_EDGE_EN
         src_q    <= 5'd0;
`endif
      end else begin
         if_q     <= if_d;
         ie_q     <= ie_d;
         dout_q   <= dout_d;
         wdin_q   <= wdin_d;
         wadr_q   <= wadr_d;
         wr_q     <= wr_d;
         pread_q  <= read;
         pwrite_q <= write;
         pack_q   <= int_ack;
`ifdef LR35902_IRQ_EDGE_EN
         src_q    <= irq_in;
`endif
      end
   end
endmodule

// File: tb/tb_lr35902_irq.sv
// tb_lr35902_irq: directed and randomized checks of lr35902_irq against a behavioural model.
module tb_lr35902_irq;
   logic       clk = 1'b0, reset = 1'b0;
   logic [7:0] dout, din = 8'd0, int_vec;
   logic       adr = 1'b0, read = 1'b0, write = 1'b0, int_ack = 1'b0, int_req;
   logic [4:0] irq_in = 5'd0;
   int         tests = 0, fails = 0;
   logic [4:0] m_if, m_src;
   logic [7:0] m_ie, m_dout, m_wdin;
   logic       m_pr, m_pw, m_pa, m_wr, m_wadr;

   lr35902_irq dut (.clk(clk), .reset(reset), .dout(dout), .din(din), .adr(adr), .read(read),
                    .write(write), .irq_in(irq_in), .int_ack(int_ack), .int_req(int_req),
                    .int_vec(int_vec));

   always #5 clk = ~clk;

   function automatic logic [7:0] vec_of(logic [4:0] f, logic [7:0] e);
      for (int n = 0; n < 5; n++) if (f[n] && e[n]) return 8'(64 + 8 * n);
      return 8'h00;
   endfunction

   task automatic model_reset();
      m_if = 0; m_ie = 0; m_dout = 0; m_src = 0; m_wdin = 0;
      m_pr = 0; m_pw = 0; m_pa = 0; m_wr = 0; m_wadr = 0;
   endtask

   task automatic model_step();
      logic [4:0] s, nf;
      logic [7:0] ne, v;
`ifdef LR35902_IRQ_EDGE_EN
      s = irq_in & ~m_src;
`else
      s = irq_in;
`endif
      nf = m_if;
      ne = m_ie;
      if (m_wr) begin
         if (m_wadr) ne = m_wdin;
         else nf = m_wdin[4:0];
      end
      if (int_ack && !m_pa) begin
         v = vec_of(m_if, m_ie);
         if (v != 8'h00) nf[(int'(v) - 64) / 8] = 1'b0;
      end
      nf = nf | s;
      if (read && !m_pr) m_dout = adr ? m_ie : {3'b111, m_if};
      m_wr = m_pw && !write;
      if (m_wr) begin
         m_wadr = adr;
         m_wdin = din;
      end
      m_if = nf; m_ie = ne; m_src = irq_in;
      m_pr = read; m_pw = write; m_pa = int_ack;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic bus_write(input logic a, input logic [7:0] d);
      adr = a; din = d; write = 1'b1;
      tick();
      write = 1'b0;
      tick();
      tick();
   endtask

   task automatic bus_read(input logic a, output logic [7:0] v);
      adr = a; read = 1'b1;
      tick();
      v = dout;
      read = 1'b0;
      tick();
   endtask

   task automatic ack_pulse();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic [7:0] v;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #2 reset = 1'b1;
      tests++; if (int_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", int_req); end
      tests++; if (int_vec !== 8'h00) begin fails++; $display("FAIL reset_vec: got %h want 00", int_vec); end
      tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h want 00", dout); end
      bus_read(1'b0, v);
      tests++; if (v !== 8'hE0) begin fails++; $display("FAIL reset_if: got %h want e0", v); end
      bus_read(1'b1, v);
      tests++; if (v !== 8'h00) begin fails++; $display("FAIL reset_ie: got %h want 00", v); end
   endtask

   task automatic test_timer();
      logic [7:0] v;
      bus_write(1'b1, 8'h04);
      irq_in = 5'b00100;
      tick();
      irq_in = 5'd0;
      tests++; if (int_req !== 1'b1) begin fails++; $display("FAIL timer_req: got %b want 1", int_req); end
      tests++; if (int_vec !== 8'h50) begin fails++; $display("FAIL timer_vec: got %h want 50", int_vec); end
      bus_read(1'b0, v);
      tests++; if (v !== 8'hE4) begin fails++; $display("FAIL timer_if: got %h want e4", v); end
      ack_pulse();
      tests++; if (int_req !== 1'b0) begin fails++; $display("FAIL timer_ack_req: got %b want 0", int_req); end
      bus_read(1'b0, v);
      tests++; if (v !== 8'hE0) begin fails++; $display("FAIL timer_ack_if: got %h want e0", v); end
   endtask

   task automatic test_priority();
      bus_write(1'b1, 8'h1F);
      irq_in = 5'b10001;
      tick();
      irq_in = 5'd0;
      tests++; if (int_vec !== 8'h40) begin fails++; $display("FAIL prio_vec0: got %h want 40", int_vec); end
      ack_pulse();
      tests++; if (int_vec !== 8'h60) begin fails++; $display("FAIL prio_vec4: got %h want 60", int_vec); end
      ack_pulse();
      tests++; if (int_req !== 1'b0) begin fails++; $display("FAIL prio_req: got %b want 0", int_req); end
   endtask

   task automatic test_cancel();
      logic [7:0] v;
      bus_write(1'b0, 8'h01);
      bus_write(1'b1, 8'h01);
      tests++; if (int_vec !== 8'h40) begin fails++; $display("FAIL cancel_pre: got %h want 40", int_vec); end
      bus_write(1'b1, 8'h00);
      tests++; if (int_vec !== 8'h00) begin fails++; $display("FAIL cancel_vec: got %h want 00", int_vec); end
      ack_pulse();
      bus_read(1'b0, v);
      tests++; if (v !== 8'hE1) begin fails++; $display("FAIL cancel_if: got %h want e1", v); end
   endtask

   task automatic test_set_wins();
      logic [7:0] v;
      adr = 1'b0; din = 8'h00; write = 1'b1;
      tick();
      write = 1'b0;
      tick();
      irq_in = 5'b01000;
      tick();
      irq_in = 5'd0;
      bus_read(1'b0, v);
      tests++; if (v !== 8'hE8) begin fails++; $display("FAIL set_wins: got %h want e8", v); end
   endtask

   task automatic test_hold();
      logic [7:0] v, e;
      logic       r;
      bus_write(1'b0, 8'h00);
      bus_write(1'b1, 8'h02);
      irq_in = 5'b00010;
      repeat (10) tick();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
`ifdef LR35902_IRQ_EDGE_EN
      r = 1'b0; e = 8'hE0;
`else
      r = 1'b1; e = 8'hE2;
`endif
      tests++; if (int_req !== r) begin fails++; $display("FAIL hold_req: got %b want %b", int_req, r); end
      tick();
      bus_read(1'b0, v);
      tests++; if (v !== e) begin fails++; $display("FAIL hold_if: got %h want %h", v, e); end
      irq_in = 5'd0;
      tick();
   endtask

   task automatic test_midreset();
      logic [7:0] v;
      irq_in = 5'b00001;
      adr = 1'b1; din = 8'hAA; write = 1'b1;
      tick();
      write = 1'b0;
      tick();
      reset = 1'b0;
      model_reset();
      #2 reset = 1'b1;
      tick();
      irq_in = 5'd0;
      bus_read(1'b1, v);
      tests++; if (v !== 8'h00) begin fails++; $display("FAIL midreset_ie: got %h want 00", v); end
      bus_read(1'b0, v);
      tests++; if (v !== 8'hE1) begin fails++; $display("FAIL midreset_if: got %h want e1", v); end
   endtask

   task automatic test_random();
      logic [7:0] ev;
      for (int i = 0; i < 600; i++) begin
         irq_in  = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
         read    = ($urandom_range(0, 2) == 0);
         write   = ($urandom_range(0, 2) == 0);
         int_ack = ($urandom_range(0, 3) == 0);
         adr     = 1'($urandom);
         din     = 8'($urandom);
         tick();
         ev = vec_of(m_if, m_ie);
         tests++; if (dout !== m_dout) begin fails++; $display("FAIL rand_dout[%0d]: got %h want %h", i, dout, m_dout); end
         tests++; if (int_vec !== ev) begin fails++; $display("FAIL rand_vec[%0d]: got %h want %h", i, int_vec, ev); end
         tests++; if (int_req !== (ev != 8'h00)) begin fails++; $display("FAIL rand_req[%0d]: got %b want %b", i, int_req, ev != 8'h00); end
      end
      irq_in = 5'd0; read = 1'b0; write = 1'b0; int_ack = 1'b0;
      tick();
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      test_reset();
      test_timer();
      test_priority();
      test_cancel();
      test_set_wins();
      test_hold();
      test_midreset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lr35902_irq.md
# lr35902_irq

Interrupt controller for the LR35902 core: directly downstream of the timer, joypad, serial, LCD STAT and VBlank sources. Collects their request pulses into the IF register (0xFF0F), masks them with IE (0xFFFF), and presents the CPU with a request line and the vector of the highest-priority pending source. On acknowledge, it clears that source's IF bit. The bus-side read/write protocol matches the other memory-mapped peripherals.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock; all state changes on its rising edge
- `reset` in 1: asynchronous, active-low reset
- `dout` out 8: read data
- `din` in 8: write data
- `adr` in 1: register select; 0 = IF (0xFF0F), 1 = IE (0xFFFF)
- `read` in 1: bus read strobe
- `write` in 1: bus write strobe
- `irq_in` in 5: source requests; bit0 VBlank, bit1 STAT, bit2 timer (the timer's single-cycle `irq`), bit3 serial, bit4 joypad
- `int_ack` in 1: CPU acknowledge strobe
- `int_req` out 1: high while `(IF & IE[4:0]) != 0`; also serves as HALT/STOP wake
- `int_vec` out 8: 0x40 + 8*n for the lowest pending enabled bit n; 0x00 if none

## Operation
- State:
  - IF[4:0]
  - IE[7:0]
  - `r_src[4:0]`: previous `irq_in`
  - `r_pread`, `r_pwrite`, `r_pack`: previous strobe levels
  - pending-write: `r_wr`, `r_adr`, `r_din`
- Source set: `set = irq_in & ~r_src`, i.e. a rising edge sets the IF bit. A level held high sets the bit once only.
- Bus write: when `r_pwrite=1` and `write=0` (write falling edge), capture `adr` and `din` and set `r_wr`. On the next edge, commit and clear `r_wr`:
  - IF address: IF = din[4:0]
  - IE address: IE = din[7:0]
- Bus read: when `r_pread=0` and `read=1`, load `dout`:
  - IF address: `{3'b111, IF}`
  - IE address: IE
  - `dout` holds its value otherwise.
- Ack: when `int_ack=1` and `r_pack=0`, clear the IF bit selected by the current `int_vec`. If `int_vec` is 0x00 (the pending request was cancelled), nothing is cleared.
- Per-edge update order for IF: pending-write commit, then ack clear, then source set. Source set therefore wins over ack and over a CPU write of 0 to the same bit.
- Priority: bit0 highest, bit4 lowest. Only IE[4:0] gates requests; IE[7:5] are storage only.
- IME lives in the CPU. This block never gates `int_req` on IME.

## Timing
- Reset (asynchronous, while `reset=0`): IF=0, IE=0, `dout`=0x00, `r_src`=0, `r_wr`=0, `r_pread`=`r_pwrite`=`r_pack`=0. Consequently `int_req`=0 and `int_vec`=0x00.
- `irq_in` first sampled high at edge k: the IF bit is 1 after edge k.
- `int_req` and `int_vec` are combinational from IF/IE registers: valid in the same cycle the registers change, with zero added latency.
- Write: falling edge of `write` detected at edge k; the register is updated at edge k+1. A read issued between k and k+1 returns the old value.
- Read: `dout` valid after the edge that detects the `read` rising edge.
- Ack: `int_ack` rising edge sampled at edge k; the bit is clear after edge k. Holding `int_ack` high clears only one bit.
- Releasing `reset` mid-operation discards any pending write. An `irq_in` level that is high at release is treated as a new edge on the first edge after release.

## Configuration
- `LR35902_IRQ_EDGE_EN`
  - Defined: source inputs are rising-edge detected, as described above.
  - Undefined: sources are level-sensitive. `set = irq_in` every cycle and `r_src` is removed. A held source re-sets its IF bit immediately after ack or after a CPU clear.

## Test plan
- Reset, then read IF and IE: `dout`=0xE0, then 0x00. `int_req`=0, `int_vec`=0x00.
- IE=0x04, pulse `irq_in[2]` for one cycle: IF reads 0xE4, `int_req`=1, `int_vec`=0x50. `int_ack` pulse leaves IF=0xE0 and `int_req`=0.
- IE=0x1F, raise `irq_in[4]` and `irq_in[0]` in the same cycle: `int_vec`=0x40. After the first ack `int_vec`=0x60; after the second ack `int_req`=0.
- IF=0x01, IE=0x01; write IE=0x00 and pulse `int_ack` after the commit: `int_vec`=0x00 at ack, IF still reads 0xE1.
- Commit a write of IF=0x00 on the same edge as an `irq_in[3]` rising edge: IF reads 0xE8 (set wins).
- Hold `irq_in[1]` high for 10 cycles, ack once:
  - With `LR35902_IRQ_EDGE_EN` defined: IF bit1=0 after ack.
  - Without it: IF bit1=1 one cycle after ack.
